// File: rtl/axi_ic_pkg.sv
// axi_ic_pkg: shared AXI interconnect widths, response codes, address map and switch FSM states
package axi_ic_pkg;
    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_RESP_WIDTH = 2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [31:0] AXI_SLV_MASK = 32'hF000_0000;
    localparam logic [31:0] AXI_S0_BASE  = 32'h0000_0000;
    localparam logic [31:0] AXI_S1_BASE  = 32'h1000_0000;
    localparam logic [31:0] AXI_S2_BASE  = 32'h2000_0000;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} axi_state_e;
endpackage

// File: rtl/axi_addr_decoder.sv
// axi_addr_decoder: masked address compare to a one-hot slave select; all-zero means unmapped
module axi_addr_decoder
    import axi_ic_pkg::*;
#(
    parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SLV_MASK   = ADDR_WIDTH'(AXI_SLV_MASK),
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(AXI_S0_BASE),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(AXI_S1_BASE),
    parameter logic [ADDR_WIDTH-1:0] S2_BASE    = ADDR_WIDTH'(AXI_S2_BASE)
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [2:0]            sel
);
    logic [ADDR_WIDTH-1:0] masked;

    assign masked = addr & SLV_MASK;
    assign sel    = {masked == S2_BASE, masked == S1_BASE, masked == S0_BASE};
endmodule

// File: rtl/slave_switch_w.sv
// slave_switch_w: routes one granted AXI write transaction to one of three slaves by address,
// answering unmapped addresses internally with DECERR and reporting busy/done to the arbiter.
module slave_switch_w
    import axi_ic_pkg::*;
#(
    parameter int                    DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                    ID_WIDTH   = AXI_ID_WIDTH,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    RESP_WIDTH = AXI_RESP_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] SLV_MASK   = ADDR_WIDTH'(AXI_SLV_MASK),
    parameter logic [ADDR_WIDTH-1:0] S0_BASE    = ADDR_WIDTH'(AXI_S0_BASE),
    parameter logic [ADDR_WIDTH-1:0] S1_BASE    = ADDR_WIDTH'(AXI_S1_BASE),
    parameter logic [ADDR_WIDTH-1:0] S2_BASE    = ADDR_WIDTH'(AXI_S2_BASE)
) (
    input  logic                  sys_clk,
    input  logic                  sys_rstn,
    input  logic [ID_WIDTH-1:0]   s_awid,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic [7:0]            s_awlen,
    input  logic [2:0]            s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  m_awready,
    input  logic [ID_WIDTH-1:0]   s_wid,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic [STRB_WIDTH-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  m_wready,
    output logic [ID_WIDTH-1:0]   m_bid,
    output logic [RESP_WIDTH-1:0] m_bresp,
    output logic                  m_bvalid,
    input  logic                  s_bready,
    output logic [ID_WIDTH-1:0]   s0_awid,
    output logic [ADDR_WIDTH-1:0] s0_awaddr,
    output logic [7:0]            s0_awlen,
    output logic [2:0]            s0_awsize,
    output logic [1:0]            s0_awburst,
    output logic                  s0_awvalid,
    input  logic                  s0_awready,
    output logic [ID_WIDTH-1:0]   s0_wid,
    output logic [DATA_WIDTH-1:0] s0_wdata,
    output logic [STRB_WIDTH-1:0] s0_wstrb,
    output logic                  s0_wlast,
    output logic                  s0_wvalid,
    input  logic                  s0_wready,
    input  logic [ID_WIDTH-1:0]   s0_bid,
    input  logic [RESP_WIDTH-1:0] s0_bresp,
    input  logic                  s0_bvalid,
    output logic                  s0_bready,
    output logic [ID_WIDTH-1:0]   s1_awid,
    output logic [ADDR_WIDTH-1:0] s1_awaddr,
    output logic [7:0]            s1_awlen,
    output logic [2:0]            s1_awsize,
    output logic [1:0]            s1_awburst,
    output logic                  s1_awvalid,
    input  logic                  s1_awready,
    output logic [ID_WIDTH-1:0]   s1_wid,
    output logic [DATA_WIDTH-1:0] s1_wdata,
    output logic [STRB_WIDTH-1:0] s1_wstrb,
    output logic                  s1_wlast,
    output logic                  s1_wvalid,
    input  logic                  s1_wready,
    input  logic [ID_WIDTH-1:0]   s1_bid,
    input  logic [RESP_WIDTH-1:0] s1_bresp,
    input  logic                  s1_bvalid,
    output logic                  s1_bready,
    output logic [ID_WIDTH-1:0]   s2_awid,
    output logic [ADDR_WIDTH-1:0] s2_awaddr,
    output logic [7:0]            s2_awlen,
    output logic [2:0]            s2_awsize,
    output logic [1:0]            s2_awburst,
    output logic                  s2_awvalid,
    input  logic                  s2_awready,
    output logic [ID_WIDTH-1:0]   s2_wid,
    output logic [DATA_WIDTH-1:0] s2_wdata,
    output logic [STRB_WIDTH-1:0] s2_wstrb,
    output logic                  s2_wlast,
    output logic                  s2_wvalid,
    input  logic                  s2_wready,
    input  logic [ID_WIDTH-1:0]   s2_bid,
    input  logic [RESP_WIDTH-1:0] s2_bresp,
    input  logic                  s2_bvalid,
    output logic                  s2_bready,
    output logic                  wr_busy,
    output logic                  wr_done,
    output logic                  wr_proto_err
);
    axi_state_e          state, state_nxt;
    logic [2:0]          sel, dec_sel, aw_en, w_en, b_en;
    logic [7:0]          beat_cnt, awlen_q;
    logic [ID_WIDTH-1:0] awid_q;
    logic                aw_hs, w_hs, b_hs, unmapped;

    axi_addr_decoder #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SLV_MASK   (SLV_MASK),
        .S0_BASE    (S0_BASE),
        .S1_BASE    (S1_BASE),
        .S2_BASE    (S2_BASE)
    ) u_dec (
        .addr (s_awaddr),
        .sel  (dec_sel)
    );

    // Each channel is steered only while the FSM is in the matching phase.
    assign aw_en    = (state == ADDR) ? sel : 3'b000;
    assign w_en     = (state == DATA) ? sel : 3'b000;
    assign b_en     = (state == RESP) ? sel : 3'b000;
    assign unmapped = (sel == 3'b000);

    assign m_awready = (state == ADDR) && (unmapped || |(sel & {s2_awready, s1_awready, s0_awready}));
    assign m_wready  = (state == DATA) && (unmapped || |(sel & {s2_wready, s1_wready, s0_wready}));
    assign m_bvalid  = (state == RESP) && (unmapped || |(sel & {s2_bvalid, s1_bvalid, s0_bvalid}));
    assign m_bid     = b_en[0] ? s0_bid : b_en[1] ? s1_bid : b_en[2] ? s2_bid :
                       (state == RESP) ? awid_q : '0;
    assign m_bresp   = b_en[0] ? s0_bresp : b_en[1] ? s1_bresp : b_en[2] ? s2_bresp :
                       (state == RESP) ? RESP_WIDTH'(RESP_DECERR) : '0;

    assign aw_hs = s_awvalid & m_awready;
    assign w_hs  = s_wvalid & m_wready;
    assign b_hs  = m_bvalid & s_bready;

    assign wr_busy      = (state != IDLE);
    assign wr_done      = b_hs;
    assign wr_proto_err = w_hs && (s_wlast ? (beat_cnt != awlen_q) : (beat_cnt == awlen_q));

    always_comb begin
        state_nxt = (state == IDLE && s_awvalid) ? ADDR :
                    aw_hs                        ? DATA :
                    (w_hs && s_wlast)            ? RESP :
                    b_hs                         ? IDLE : state;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            sel      <= 3'b000;
            awid_q   <= '0;
            awlen_q  <= '0;
            beat_cnt <= '0;
        end else begin
            if (state == IDLE && s_awvalid) begin
                sel     <= dec_sel;
                awid_q  <= s_awid;
                awlen_q <= s_awlen;
            end
            if (b_hs)
                beat_cnt <= '0;
            else if (w_hs && beat_cnt != 8'hFF)
                beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign s0_awvalid = aw_en[0] & s_awvalid;
    assign s0_awid    = aw_en[0] ? s_awid : '0;
    assign s0_awaddr  = aw_en[0] ? s_awaddr : '0;
    assign s0_awlen   = aw_en[0] ? s_awlen : '0;
    assign s0_awsize  = aw_en[0] ? s_awsize : '0;
    assign s0_awburst = aw_en[0] ? s_awburst : '0;
    assign s0_wvalid  = w_en[0] & s_wvalid;
    assign s0_wid     = w_en[0] ? s_wid : '0;
    assign s0_wdata   = w_en[0] ? s_wdata : '0;
    assign s0_wstrb   = w_en[0] ? s_wstrb : '0;
    assign s0_wlast   = w_en[0] & s_wlast;
    assign s0_bready  = b_en[0] & s_bready;

    assign s1_awvalid = aw_en[1] & s_awvalid;
    assign s1_awid    = aw_en[1] ? s_awid : '0;
    assign s1_awaddr  = aw_en[1] ? s_awaddr : '0;
    assign s1_awlen   = aw_en[1] ? s_awlen : '0;
    assign s1_awsize  = aw_en[1] ? s_awsize : '0;
    assign s1_awburst = aw_en[1] ? s_awburst : '0;
    assign s1_wvalid  = w_en[1] & s_wvalid;
    assign s1_wid     = w_en[1] ? s_wid : '0;
    assign s1_wdata   = w_en[1] ? s_wdata : '0;
    assign s1_wstrb   = w_en[1] ? s_wstrb : '0;
    assign s1_wlast   = w_en[1] & s_wlast;
    assign s1_bready  = b_en[1] & s_bready;

    assign s2_awvalid = aw_en[2] & s_awvalid;
    assign s2_awid    = aw_en[2] ? s_awid : '0;
    assign s2_awaddr  = aw_en[2] ? s_awaddr : '0;
    assign s2_awlen   = aw_en[2] ? s_awlen : '0;
    assign s2_awsize  = aw_en[2] ? s_awsize : '0;
    assign s2_awburst = aw_en[2] ? s_awburst : '0;
    assign s2_wvalid  = w_en[2] & s_wvalid;
    assign s2_wid     = w_en[2] ? s_wid : '0;
    assign s2_wdata   = w_en[2] ? s_wdata : '0;
    assign s2_wstrb   = w_en[2] ? s_wstrb : '0;
    assign s2_wlast   = w_en[2] & s_wlast;
    assign s2_bready  = b_en[2] & s_bready;
endmodule

// File: tb/tb_slave_switch_w.sv
// tb_slave_switch_w: directed scenarios for the write-channel slave switch with hand-computed expectations
module tb_slave_switch_w;
    logic        sys_clk = 1'b0;
    logic        sys_rstn;
    logic [3:0]  s_awid, s_wid, m_bid;
    logic [31:0] s_awaddr, s_wdata;
    logic [7:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awburst, m_bresp;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, m_awready, s_wlast, s_wvalid, m_wready, m_bvalid, s_bready;
    logic [3:0]  s0_awid, s1_awid, s2_awid, s0_wid, s1_wid, s2_wid, s0_bid, s1_bid, s2_bid;
    logic [31:0] s0_awaddr, s1_awaddr, s2_awaddr, s0_wdata, s1_wdata, s2_wdata;
    logic [7:0]  s0_awlen, s1_awlen, s2_awlen;
    logic [2:0]  s0_awsize, s1_awsize, s2_awsize;
    logic [1:0]  s0_awburst, s1_awburst, s2_awburst, s0_bresp, s1_bresp, s2_bresp;
    logic [3:0]  s0_wstrb, s1_wstrb, s2_wstrb;
    logic        s0_awvalid, s1_awvalid, s2_awvalid, s0_awready, s1_awready, s2_awready;
    logic        s0_wlast, s1_wlast, s2_wlast, s0_wvalid, s1_wvalid, s2_wvalid;
    logic        s0_wready, s1_wready, s2_wready, s0_bvalid, s1_bvalid, s2_bvalid;
    logic        s0_bready, s1_bready, s2_bready;
    logic        wr_busy, wr_done, wr_proto_err;
    logic [14:0] ctl;
    int          checks = 0;
    int          errors = 0;

    always #5 sys_clk = ~sys_clk;

    assign ctl = {m_awready, m_wready, m_bvalid, wr_busy, wr_done, wr_proto_err,
                  s0_awvalid, s0_wvalid, s0_bready, s1_awvalid, s1_wvalid, s1_bready,
                  s2_awvalid, s2_wvalid, s2_bready};

    slave_switch_w dut (
        .sys_clk(sys_clk), .sys_rstn(sys_rstn),
        .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
        .s_awburst(s_awburst), .s_awvalid(s_awvalid), .m_awready(m_awready),
        .s_wid(s_wid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .s_bready(s_bready),
        .s0_awid(s0_awid), .s0_awaddr(s0_awaddr), .s0_awlen(s0_awlen), .s0_awsize(s0_awsize),
        .s0_awburst(s0_awburst), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wid(s0_wid), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wlast(s0_wlast),
        .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_awid(s1_awid), .s1_awaddr(s1_awaddr), .s1_awlen(s1_awlen), .s1_awsize(s1_awsize),
        .s1_awburst(s1_awburst), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wid(s1_wid), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wlast(s1_wlast),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s2_awid(s2_awid), .s2_awaddr(s2_awaddr), .s2_awlen(s2_awlen), .s2_awsize(s2_awsize),
        .s2_awburst(s2_awburst), .s2_awvalid(s2_awvalid), .s2_awready(s2_awready),
        .s2_wid(s2_wid), .s2_wdata(s2_wdata), .s2_wstrb(s2_wstrb), .s2_wlast(s2_wlast),
        .s2_wvalid(s2_wvalid), .s2_wready(s2_wready),
        .s2_bid(s2_bid), .s2_bresp(s2_bresp), .s2_bvalid(s2_bvalid), .s2_bready(s2_bready),
        .wr_busy(wr_busy), .wr_done(wr_done), .wr_proto_err(wr_proto_err)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic clear_inputs;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0; s_awvalid = 1'b0;
        s_wid = '0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0;
        s0_awready = 1'b0; s0_wready = 1'b0; s0_bid = '0; s0_bresp = '0; s0_bvalid = 1'b0;
        s1_awready = 1'b0; s1_wready = 1'b0; s1_bid = '0; s1_bresp = '0; s1_bvalid = 1'b0;
        s2_awready = 1'b0; s2_wready = 1'b0; s2_bid = '0; s2_bresp = '0; s2_bvalid = 1'b0;
    endtask

    // Presents AW in IDLE and advances one clock, leaving the switch in ADDR.
    task automatic issue_aw(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len);
        s_awaddr = a; s_awid = id; s_awlen = len; s_awsize = 3'd2; s_awburst = 2'b01; s_awvalid = 1'b1;
        tick;
    endtask

    task automatic test_reset;
        clear_inputs;
        sys_rstn = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++;
        if ({ctl, m_bid, m_bresp} !== 21'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h exp 0", {ctl, m_bid, m_bresp});
        end
        sys_rstn = 1'b1;
        tick;
    endtask

    task automatic test_s1_write;
        s1_awready = 1'b1; s1_wready = 1'b1;
        s_awaddr = 32'h1000_0040; s_awid = 4'h5; s_awlen = 8'd3; s_awsize = 3'd2; s_awburst = 2'b01;
        s_awvalid = 1'b1;
        #1;
        checks++;
        if ({m_awready, s1_awvalid} !== 2'b00) begin
            errors++;
            $display("FAIL s1_idle_aw: got %b exp 00", {m_awready, s1_awvalid});
        end
        tick;
        checks++;
        if ({m_awready, s0_awvalid, s1_awvalid, s2_awvalid, s1_awaddr, s1_awlen} !== {4'b1010, 32'h1000_0040, 8'd3}) begin
            errors++;
            $display("FAIL s1_addr: got %h exp %h", {m_awready, s0_awvalid, s1_awvalid, s2_awvalid, s1_awaddr, s1_awlen},
                     {4'b1010, 32'h1000_0040, 8'd3});
        end
        tick;
        s_awvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_wvalid = 1'b1; s_wid = 4'h5; s_wstrb = 4'hF; s_wdata = 32'hA000_0000 + i; s_wlast = (i == 3);
            #1;
            checks++;
            if ({s0_wvalid, s1_wvalid, s2_wvalid, s1_wdata, s1_wlast, m_wready, wr_proto_err} !==
                {3'b010, 32'hA000_0000 + i, (i == 3), 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL s1_beat%0d: got %h exp %h", i,
                         {s0_wvalid, s1_wvalid, s2_wvalid, s1_wdata, s1_wlast, m_wready, wr_proto_err},
                         {3'b010, 32'hA000_0000 + i, (i == 3), 1'b1, 1'b0});
            end
            tick;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s1_bvalid = 1'b1; s1_bid = 4'h5; s1_bresp = 2'b00; s_bready = 1'b1;
        #1;
        checks++;
        if ({m_bvalid, m_bresp, m_bid, wr_done, s0_bready, s1_bready, s2_bready} !== {1'b1, 2'b00, 4'h5, 1'b1, 3'b010}) begin
            errors++;
            $display("FAIL s1_resp: got %h exp %h", {m_bvalid, m_bresp, m_bid, wr_done, s0_bready, s1_bready, s2_bready},
                     {1'b1, 2'b00, 4'h5, 1'b1, 3'b010});
        end
        tick;
        clear_inputs;
        #1;
        checks++;
        if ({wr_busy, wr_done} !== 2'b00) begin
            errors++;
            $display("FAIL s1_after_done: got %b exp 00", {wr_busy, wr_done});
        end
    endtask

    task automatic test_decerr;
        issue_aw(32'h5000_0000, 4'hA, 8'd1);
        checks++;
        if ({m_awready, s0_awvalid, s1_awvalid, s2_awvalid} !== 4'b1000) begin
            errors++;
            $display("FAIL decerr_addr: got %b exp 1000", {m_awready, s0_awvalid, s1_awvalid, s2_awvalid});
        end
        tick;
        s_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_wvalid = 1'b1; s_wdata = 32'h5555_0000 + i; s_wlast = (i == 1);
            #1;
            checks++;
            if ({m_wready, s0_wvalid, s1_wvalid, s2_wvalid, wr_proto_err} !== 5'b10000) begin
                errors++;
                $display("FAIL decerr_beat%0d: got %b exp 10000", i, {m_wready, s0_wvalid, s1_wvalid, s2_wvalid, wr_proto_err});
            end
            tick;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s_bready = 1'b1;
        #1;
        checks++;
        if ({m_bvalid, m_bresp, m_bid, wr_done, s0_bready, s1_bready, s2_bready} !== {1'b1, 2'b11, 4'hA, 1'b1, 3'b000}) begin
            errors++;
            $display("FAIL decerr_resp: got %h exp %h", {m_bvalid, m_bresp, m_bid, wr_done, s0_bready, s1_bready, s2_bready},
                     {1'b1, 2'b11, 4'hA, 1'b1, 3'b000});
        end
        tick;
        clear_inputs;
    endtask

    task automatic test_stall_s2;
        logic [31:0] got [4];
        int          n = 0;
        int          beat = 0;
        logic        rdy;
        issue_aw(32'h2000_0100, 4'h9, 8'd3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s2_awvalid, s2_awaddr, s2_awid, m_awready} !== {1'b1, 32'h2000_0100, 4'h9, 1'b0}) begin
                errors++;
                $display("FAIL stall_aw%0d: got %h exp %h", i, {s2_awvalid, s2_awaddr, s2_awid, m_awready},
                         {1'b1, 32'h2000_0100, 4'h9, 1'b0});
            end
            tick;
        end
        s2_awready = 1'b1;
        #1;
        checks++;
        if (m_awready !== 1'b1) begin
            errors++;
            $display("FAIL stall_aw_accept: got %b exp 1", m_awready);
        end
        tick;
        s_awvalid = 1'b0; s2_awready = 1'b0;
        for (int c = 0; c < 20 && beat < 4; c++) begin
            rdy = c[0];
            s2_wready = rdy; s_wvalid = 1'b1; s_wdata = 32'hC0DE_0000 + beat; s_wlast = (beat == 3);
            #1;
            checks++;
            if ({s2_wvalid, s2_wdata, m_wready, wr_proto_err} !== {1'b1, 32'hC0DE_0000 + beat, rdy, 1'b0}) begin
                errors++;
                $display("FAIL stall_w_cyc%0d: got %h exp %h", c, {s2_wvalid, s2_wdata, m_wready, wr_proto_err},
                         {1'b1, 32'hC0DE_0000 + beat, rdy, 1'b0});
            end
            if (s2_wvalid && s2_wready && n < 4) begin
                got[n] = s2_wdata;
                n++;
                beat++;
            end
            tick;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0; s2_wready = 1'b0;
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL stall_beat_count: got %0d exp 4", n);
        end
        for (int k = 0; k < n; k++) begin
            checks++;
            if (got[k] !== 32'hC0DE_0000 + k) begin
                errors++;
                $display("FAIL stall_order%0d: got %h exp %h", k, got[k], 32'hC0DE_0000 + k);
            end
        end
        s2_bvalid = 1'b1; s2_bid = 4'h9; s2_bresp = 2'b10; s_bready = 1'b1;
        #1;
        checks++;
        if ({m_bvalid, m_bresp, m_bid, s2_bready, wr_done} !== {1'b1, 2'b10, 4'h9, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL stall_resp: got %h exp %h", {m_bvalid, m_bresp, m_bid, s2_bready, wr_done},
                     {1'b1, 2'b10, 4'h9, 1'b1, 1'b1});
        end
        tick;
        clear_inputs;
    endtask

    task automatic test_proto_err;
        s0_awready = 1'b1; s0_wready = 1'b1;
        issue_aw(32'h0000_0010, 4'h3, 8'd3);
        tick;
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'h1; s_wlast = 1'b0;
        #1;
        checks++;
        if ({s0_wvalid, wr_proto_err} !== 2'b10) begin
            errors++;
            $display("FAIL proto_beat0: got %b exp 10", {s0_wvalid, wr_proto_err});
        end
        tick;
        s_wdata = 32'h2; s_wlast = 1'b1;
        #1;
        checks++;
        if ({s0_wvalid, wr_proto_err} !== 2'b11) begin
            errors++;
            $display("FAIL proto_early_last: got %b exp 11", {s0_wvalid, wr_proto_err});
        end
        tick;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s0_bvalid = 1'b1; s0_bid = 4'h3; s0_bresp = 2'b00; s_bready = 1'b1;
        #1;
        checks++;
        if ({wr_proto_err, m_wready, m_bvalid, m_bresp, m_bid, wr_done} !== {1'b0, 1'b0, 1'b1, 2'b00, 4'h3, 1'b1}) begin
            errors++;
            $display("FAIL proto_resp: got %h exp %h", {wr_proto_err, m_wready, m_bvalid, m_bresp, m_bid, wr_done},
                     {1'b0, 1'b0, 1'b1, 2'b00, 4'h3, 1'b1});
        end
        tick;
        clear_inputs;
        s0_awready = 1'b1; s0_wready = 1'b1;
        issue_aw(32'h0000_0020, 4'h6, 8'd1);
        tick;
        s_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_wvalid = 1'b1; s_wdata = 32'h10 + i; s_wlast = (i == 2);
            #1;
            checks++;
            if ({m_wready, wr_proto_err} !== {1'b1, (i != 0)}) begin
                errors++;
                $display("FAIL proto_late_beat%0d: got %b exp %b", i, {m_wready, wr_proto_err}, {1'b1, (i != 0)});
            end
            tick;
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s0_bvalid = 1'b1; s0_bid = 4'h6; s_bready = 1'b1;
        #1;
        checks++;
        if ({m_bvalid, m_bid, wr_done} !== {1'b1, 4'h6, 1'b1}) begin
            errors++;
            $display("FAIL proto_late_resp: got %h exp %h", {m_bvalid, m_bid, wr_done}, {1'b1, 4'h6, 1'b1});
        end
        tick;
        clear_inputs;
    endtask

    task automatic test_reset_mid;
        s0_awready = 1'b1; s0_wready = 1'b1;
        issue_aw(32'h0800_0000, 4'h2, 8'd3);
        tick;
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'hDEAD_0000; s_wlast = 1'b0;
        #1;
        checks++;
        if (s0_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got %b exp 1", s0_wvalid);
        end
        tick;
        sys_rstn = 1'b0;
        #1;
        checks++;
        if ({ctl, m_bid, m_bresp, s0_wdata} !== 53'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got %h exp 0", {ctl, m_bid, m_bresp, s0_wdata});
        end
        clear_inputs;
        tick;
        sys_rstn = 1'b1;
        tick;
        s2_awready = 1'b1; s2_wready = 1'b1;
        issue_aw(32'h2000_0000, 4'h7, 8'd0);
        checks++;
        if ({s0_awvalid, s2_awvalid, m_awready} !== 3'b011) begin
            errors++;
            $display("FAIL rst_next_aw: got %b exp 011", {s0_awvalid, s2_awvalid, m_awready});
        end
        tick;
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'h7777_0001; s_wlast = 1'b1;
        #1;
        checks++;
        if ({s0_wvalid, s2_wvalid, s2_wdata, s2_wlast, wr_proto_err} !== {2'b01, 32'h7777_0001, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rst_next_w: got %h exp %h", {s0_wvalid, s2_wvalid, s2_wdata, s2_wlast, wr_proto_err},
                     {2'b01, 32'h7777_0001, 1'b1, 1'b0});
        end
        tick;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s2_bvalid = 1'b1; s2_bid = 4'h7; s2_bresp = 2'b00; s_bready = 1'b1;
        #1;
        checks++;
        if ({m_bvalid, m_bresp, m_bid, wr_done} !== {1'b1, 2'b00, 4'h7, 1'b1}) begin
            errors++;
            $display("FAIL rst_next_resp: got %h exp %h", {m_bvalid, m_bresp, m_bid, wr_done}, {1'b1, 2'b00, 4'h7, 1'b1});
        end
        tick;
        clear_inputs;
    endtask

    task automatic test_b_hold;
        s0_awready = 1'b1; s0_wready = 1'b1;
        issue_aw(32'h0000_0100, 4'hC, 8'd0);
        tick;
        s_awvalid = 1'b0;
        s_wvalid = 1'b1; s_wdata = 32'hB0B0_0000; s_wlast = 1'b1;
        tick;
        s_wvalid = 1'b0; s_wlast = 1'b0;
        s0_bvalid = 1'b1; s0_bid = 4'hC; s0_bresp = 2'b00; s_bready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({m_bvalid, s0_bready, wr_done, wr_busy} !== 4'b1001) begin
                errors++;
                $display("FAIL bhold_cyc%0d: got %b exp 1001", i, {m_bvalid, s0_bready, wr_done, wr_busy});
            end
            tick;
        end
        s_bready = 1'b1;
        #1;
        checks++;
        if ({s0_bready, wr_done, m_bid, m_bresp} !== {1'b1, 1'b1, 4'hC, 2'b00}) begin
            errors++;
            $display("FAIL bhold_release: got %h exp %h", {s0_bready, wr_done, m_bid, m_bresp}, {1'b1, 1'b1, 4'hC, 2'b00});
        end
        tick;
        clear_inputs;
        #1;
        checks++;
        if ({wr_busy, wr_done, m_bvalid} !== 3'b000) begin
            errors++;
            $display("FAIL bhold_idle: got %b exp 000", {wr_busy, wr_done, m_bvalid});
        end
    endtask

    initial begin
        test_reset;
        test_s1_write;
        test_decerr;
        test_stall_s2;
        test_proto_err;
        test_reset_mid;
        test_b_hold;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/slave_switch_w.md
Name: slave_switch_w

Overview:
Slave-side write-channel demultiplexer of the AXI interconnect. It takes the single granted write stream produced by the master-side write mux and decodes AWADDR to one of three slaves. It routes AW and W to that slave and returns the slave's B response upstream. It also contains an internal default slave that answers unmapped addresses with DECERR, and it reports busy/done status to the write arbiter so the grant is held for the whole transaction.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address width
ID_WIDTH, 4, transaction ID width
STRB_WIDTH, DATA_WIDTH/8, write strobe width
RESP_WIDTH, 2, response width
SLV_MASK, 32'hF000_0000, address bits compared for decode
S0_BASE, 32'h0000_0000, slave 0 base (masked compare)
S1_BASE, 32'h1000_0000, slave 1 base
S2_BASE, 32'h2000_0000, slave 2 base

Ports:
sys_clk  in  1  clock
sys_rstn  in  1  asynchronous active-low reset
s_awid/s_awaddr/s_awlen/s_awsize/s_awburst/s_awvalid  in  ID/ADDR/8/3/2/1  AW from write mux
m_awready  out  1  AW ready to write mux
s_wid/s_wdata/s_wstrb/s_wlast/s_wvalid  in  ID/DATA/STRB/1/1  W from write mux
m_wready  out  1  W ready to write mux
m_bid/m_bresp/m_bvalid  out  ID/RESP/1  B to write mux
s_bready  in  1  B ready from write mux
sN_awid/sN_awaddr/sN_awlen/sN_awsize/sN_awburst/sN_awvalid (N=0..2)  out  ID/ADDR/8/3/2/1  AW to slave N
sN_awready  in  1  from slave N
sN_wid/sN_wdata/sN_wstrb/sN_wlast/sN_wvalid  out  ID/DATA/STRB/1/1  W to slave N
sN_wready  in  1  from slave N
sN_bid/sN_bresp/sN_bvalid  in  ID/RESP/1  B from slave N
sN_bready  out  1  to slave N
wr_busy  out  1  high whenever FSM not IDLE
wr_done  out  1  one-cycle pulse on B handshake
wr_proto_err  out  1  one-cycle pulse on WLAST/AWLEN mismatch

Behaviour:
- Reset: asynchronous, active-low on sys_rstn. FSM goes to IDLE; sel=3'b000, beat_cnt=0, latched awid/awlen=0. Every valid, ready, wr_busy, wr_done and wr_proto_err output is 0. Mid-transaction reset aborts with no response.
- States: IDLE, ADDR, DATA, RESP.
- IDLE: m_awready=0 and m_wready=0. When s_awvalid=1, register the decode: sel one-hot = (s_awaddr & SLV_MASK) == Sn_BASE, or 3'b000 (decode error). Latch awid and awlen, then go to ADDR. One-cycle decode latency.
- ADDR: the selected sN_aw* mirrors s_aw* combinationally and m_awready = sN_awready. If sel=0, m_awready=1 (internal accept). Go to DATA on s_awvalid & m_awready.
- DATA: the selected sN_w* mirrors s_w* and m_wready = sN_wready. If sel=0, m_wready=1 and beats are sunk. beat_cnt increments on each W handshake.
  - Go to RESP on the handshake with s_wlast=1.
  - Pulse wr_proto_err if that beat has beat_cnt != awlen, or if a beat with beat_cnt == awlen handshakes without wlast.
  - W presented in IDLE or ADDR is not accepted (m_wready=0).
- RESP: the selected sN_b* drives m_b* and sN_bready = s_bready. If sel=0: m_bvalid=1, m_bresp=2'b11 (DECERR), m_bid = latched awid. On m_bvalid & s_bready: pulse wr_done, clear beat_cnt, go to IDLE.
- Unselected slaves: all valids/readies 0, payloads 0, at all times.
- Any valid already asserted toward a slave stays asserted with stable payload until its handshake; a stall of any length is legal.
- Single outstanding transaction; a new AW is accepted only after wr_done.
- beat_cnt is 8 bits and does not wrap past 255 (awlen max 255).

Decomposition:
- Shared package axi_ic_pkg holds:
  - width defaults
  - RESP codes OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11
  - address map constants SLV_MASK, S0..S2_BASE
  - FSM state encoding, shared with the read-side switch
- One combinational sub-module, axi_addr_decoder (addr -> 3-bit one-hot sel, all-zero = unmapped), is reused by the read-channel slave switch.

Test Plan:
- AW addr 32'h1000_0040, awlen=3, 4 beats with wlast on beat 4, s1 B OKAY -> only s1 sees AW and W. m_bresp=2'b00, m_bid=awid, wr_done pulses once, wr_busy falls the following cycle.
- AW addr 32'h5000_0000, awlen=1, 2 beats -> no sN valid asserted. m_awready and m_wready are 1 in the relevant states; m_bvalid with bresp=2'b11 and bid=awid.
- s2 holds awready=0 for 5 cycles, then wready toggles every other cycle -> sN_awvalid and W payload stay stable until handshake. All 4 beats are delivered in order with no duplicates.
- awlen=3 with wlast on beat 2 -> wr_proto_err pulses on beat 2, FSM goes to RESP, and s0's response is still returned.
- sys_rstn asserted during DATA of an s0 burst -> all outputs are 0 immediately. The next transaction to s2 completes normally.
- m_bvalid held with s_bready=0 for 10 cycles -> s0_bready=0 throughout. wr_done pulses only on the cycle s_bready=1.
